// File: rtl/chaos_pkg.sv
// Shared constants and scheduler state encoding for the chaos generator path.
// Widths and gain settings here must match the logistic_seq instance.
package chaos_pkg;

  localparam int CHAOS_OVLD_W_DEF = 32;
  localparam int GAIN_INDEX       = 3;
  localparam int ITERATIONS       = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } sched_state_t;

endpackage

// File: rtl/chaos_gen_sched_rr_arb.sv
// Round-robin arbiter: the first set request at or after ptr wins.
// Purely combinational; it returns a one-hot grant and the winning index.
module rr_arb
  import chaos_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/chaos_gen_sched.sv
// Shares one logistic_seq generator between requesters, one job at a time.
// Each sample is fed back as the next seed until the job's count is exhausted.
module chaos_gen_sched
  import chaos_pkg::*;
#(
  parameter int CHAOS_OVLD_W = CHAOS_OVLD_W_DEF,
  parameter int NUM_REQ      = 2,
  parameter int CNT_W        = 8,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*CHAOS_OVLD_W-1:0] req_x0,
  input  logic [NUM_REQ*CNT_W-1:0]        req_len,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_rdy,
  output logic [CHAOS_OVLD_W-1:0]         rsp_x,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_last,
  output logic                            rsp_vld,
  input  logic                            rsp_rdy,
  output logic [CHAOS_OVLD_W-1:0]         gen_x0,
  output logic                            gen_x0_vld,
  input  logic                            gen_x0_rdy,
  input  logic [CHAOS_OVLD_W-1:0]         gen_xout,
  input  logic                            gen_xout_vld,
  output logic                            gen_xout_rdy
);

  sched_state_t            state_q, state_d;
  logic [CHAOS_OVLD_W-1:0] cur_x_q, cur_x_d;
  logic [CNT_W-1:0]        remain_q, remain_d;
  logic [ID_W-1:0]         cur_id_q, cur_id_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]      gnt;
  logic [ID_W-1:0]         gnt_idx;
  logic                    gnt_vld;
  logic [CNT_W-1:0]        len_sel;
  logic                    last;

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req     (req_vld),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign last = (remain_q == CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    remain_d = remain_q;
    cur_id_d = cur_id_q;
    rr_ptr_d = rr_ptr_q;
    len_sel  = req_len[gnt_idx*CNT_W +: CNT_W];
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          cur_x_d  = req_x0[gnt_idx*CHAOS_OVLD_W +: CHAOS_OVLD_W];
          // A zero count still produces one sample
          remain_d = (len_sel == '0) ? CNT_W'(1) : len_sel;
          cur_id_d = gnt_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (gen_x0_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (gen_xout_vld) begin
          cur_x_d = gen_xout;
          state_d = OUT;
        end
      end
      OUT: begin
        if (rsp_rdy) begin
          if (last) begin
            rr_ptr_d = (cur_id_q == ID_W'(NUM_REQ - 1)) ?
                       '0 : cur_id_q + 1'b1;
            state_d  = IDLE;
          end else begin
            remain_d = remain_q - 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_x_q  <= '0;
      remain_q <= '0;
      cur_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      remain_q <= remain_d;
      cur_id_q <= cur_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Grant is combinational; rst masks it since IDLE is forced during reset
  assign req_rdy      = (state_q == IDLE && !rst) ? gnt : '0;
  assign gen_x0       = cur_x_q;
  assign gen_x0_vld   = (state_q == ISSUE);
  assign gen_xout_rdy = (state_q == WAIT);
  assign rsp_vld      = (state_q == OUT);
  assign rsp_x        = cur_x_q;
  assign rsp_id       = cur_id_q;
  assign rsp_last     = (state_q == OUT) && last;

endmodule
